cordic_hardware: RTL and testbench

Pipelined CORDIC vector rotator on IEEE-754 single-precision operands. It rotates the point (x1, y1) by an angle given in degrees and returns the rotated point (x2, y2), also in single precision. It accepts one new operand set per clock and is used as a rotation/transform engine in the DCT datapath.

---
 rtl/cordic_hardware.sv | 178 +++++++++++++++++
 tb/tb_cordic_hardware.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cordic_hardware.sv
// cordic_hardware
//   Pipelined CORDIC vector rotator on IEEE-754 single-precision operands.
//   Rotates (x1, y1) counter-clockwise by 'angle' degrees and returns (x2, y2).
//   One operand set per clock. Registers: input conversion, quadrant
//   pre-rotation, I micro-rotations, output conversion. The result is held on
//   x2/y2 I+2 edges after the edge that samples the operands.
//
// Ports
//   clk    rising-edge clock
//   clr    asynchronous active-low reset, clears every pipeline register
//   x1     x coordinate, float
//   y1     y coordinate, float
//   angle  rotation angle in degrees, float, valid range [-180, 180]
//   x2     x1*cos(angle) - y1*sin(angle), float
//   y2     x1*sin(angle) + y1*cos(angle), float
module cordic_hardware #(
  parameter int M = 23,
  parameter int E = 8,
  parameter int I = 12
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [M+E:0] x1,
  input  logic [M+E:0] y1,
  input  logic [M+E:0] angle,
  output logic [M+E:0] x2,
  output logic [M+E:0] y2
);

  localparam int W    = M + E + 1;
  localparam int XW   = 34;                 // Q15.16 plus 2 guard bits
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam logic signed [31:0] DEG90  = 32'sd5898240;
  localparam logic signed [31:0] DEG180 = 32'sd11796480;
  localparam logic signed [47:0] INV_K  = 48'sd39797;

  // atan(2^-k) in degrees, Q16, rounded
  function automatic logic signed [31:0] atan_q16(input int k);
    case (k)
      0:       return 32'sd2949120;
      1:       return 32'sd1740967;
      2:       return 32'sd919879;
      3:       return 32'sd466945;
      4:       return 32'sd234379;
      5:       return 32'sd117304;
      6:       return 32'sd58666;
      7:       return 32'sd29335;
      8:       return 32'sd14668;
      9:       return 32'sd7334;
      10:      return 32'sd3667;
      11:      return 32'sd1833;
      default: return 32'sd0;
    endcase
  endfunction

  // float -> Q15.16, truncating; zero/denormal -> 0, |v| >= 2^15/Inf/NaN -> +-max
  function automatic logic signed [31:0] f2fix(input logic [W-1:0] f);
    logic [E-1:0] e;
    logic [M:0]   mant;
    logic [31:0]  mag;
    int           sh;
    e    = f[W-2:M];
    mant = {1'b1, f[M-1:0]};
    sh   = int'(e) - BIAS - M + 16;
    if (e == '0)
      mag = '0;
    else if (int'(e) - BIAS >= 15)
      mag = 32'h7FFF_FFFF;
    else if (sh >= 0)
      mag = 32'(mant) << sh;
    else if (-sh > M)
      mag = '0;
    else
      mag = 32'(mant >> (-sh));
    return f[W-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // Pre-scale by 1/K so the CORDIC gain cancels; result widened to XW
  function automatic logic signed [XW-1:0] inv_k(input logic signed [31:0] v);
    logic signed [47:0] p;
    p = $signed({{16{v[31]}}, v}) * INV_K;
    return {{2{p[47]}}, p[47:16]};
  endfunction

  // Q16 fixed (with guard bits) -> float, truncating; 0 -> +0
  function automatic logic [W-1:0] fix2f(input logic signed [XW-1:0] v);
    logic [XW-1:0] mag;
    logic [XW-1:0] norm;
    int            p;
    mag = v[XW-1] ? -v : v;
    p   = 0;
    for (int k = 0; k < XW; k++)
      if (mag[k]) p = k;
    if (mag == '0) return '0;
    norm = mag << (XW - 1 - p);
    return {v[XW-1], E'(p - 16 + BIAS), norm[XW-2 -: M]};
  endfunction

  logic signed [XW-1:0] xa_q, ya_q, xb_q, yb_q;
  logic signed [31:0]   za_q, zb_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      xa_q <= '0;
      ya_q <= '0;
      za_q <= '0;
    end else begin
      xa_q <= inv_k(f2fix(x1));
      ya_q <= inv_k(f2fix(y1));
      za_q <= f2fix(angle);
    end
  end

  // Fold |angle| > 90 into [-90, 90] by a 180-degree turn (negate x, y)
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      xb_q <= '0;
      yb_q <= '0;
      zb_q <= '0;
    end else if (za_q > DEG90) begin
      xb_q <= -xa_q;
      yb_q <= -ya_q;
      zb_q <= za_q - DEG180;
    end else if (za_q < -DEG90) begin
      xb_q <= -xa_q;
      yb_q <= -ya_q;
      zb_q <= za_q + DEG180;
    end else begin
      xb_q <= xa_q;
      yb_q <= ya_q;
      zb_q <= za_q;
    end
  end

  for (genvar i = 0; i < I; i++) begin : g_stage
    localparam logic signed [31:0] ATAN = atan_q16(i);
    logic signed [XW-1:0] xin, yin, x_q, y_q;
    logic signed [31:0]   zin, z_q;

    if (i == 0) begin : g_first
      assign xin = xb_q;
      assign yin = yb_q;
      assign zin = zb_q;
    end else begin : g_next
      assign xin = g_stage[i-1].x_q;
      assign yin = g_stage[i-1].y_q;
      assign zin = g_stage[i-1].z_q;
    end

    // d = +1 when z >= 0
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        x_q <= '0;
        y_q <= '0;
        z_q <= '0;
      end else if (!zin[31]) begin
        x_q <= xin - (yin >>> i);
        y_q <= yin + (xin >>> i);
        z_q <= zin - ATAN;
      end else begin
        x_q <= xin + (yin >>> i);
        y_q <= yin - (xin >>> i);
        z_q <= zin + ATAN;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      x2 <= '0;
      y2 <= '0;
    end else begin
      x2 <= fix2f(g_stage[I-1].x_q);
      y2 <= fix2f(g_stage[I-1].y_q);
    end
  end

endmodule

// File: tb/tb_cordic_hardware.sv
// Bench for cordic_hardware: directed vectors from the rotation examples plus
// randomized operands, compared against a real-arithmetic rotation model
// through a 14-edge delay line of expected results.
module tb_cordic_hardware;

  localparam int LAT = 14;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] x1, y1, angle;
  logic [31:0] x2, y2;

  int n_checks = 0;
  int n_errors = 0;

  // Expected results, one entry per sampled edge; zero entries are bit-exact 0
  bit  q_zero[$];
  real q_ex[$];
  real q_ey[$];
  real q_tol[$];

  cordic_hardware #(.M(23), .E(8), .I(12)) dut (
    .clk   (clk),
    .clr   (clr),
    .x1    (x1),
    .y1    (y1),
    .angle (angle),
    .x2    (x2),
    .y2    (y2)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    int          e;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    d = {f[31], 11'(e - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic real rand_coord();
    real m;
    m = 1.0 + real'($urandom_range(0, 49900)) / 100.0;
    return ($urandom_range(0, 1) == 1) ? -m : m;
  endfunction

  function automatic real rand_angle();
    return real'($urandom_range(0, 36000)) / 100.0 - 180.0;
  endfunction

  task automatic check_val(input string tag, input real got, input real want, input real tol);
    n_checks++;
    if (!((got - want) <= tol && (want - got) <= tol)) begin
      n_errors++;
      $display("FAIL %s: got %f, expected %f (tol %g)", tag, got, want, tol);
    end
  endtask

  task automatic push_model(input logic [31:0] xb, input logic [31:0] yb, input logic [31:0] ab);
    real xr, yr, th;
    xr = f2r(xb);
    yr = f2r(yb);
    th = f2r(ab) * 3.14159265358979323846 / 180.0;
    q_zero.push_back(1'b0);
    q_ex.push_back(xr * $cos(th) - yr * $sin(th));
    q_ey.push_back(xr * $sin(th) + yr * $cos(th));
    q_tol.push_back(1.0e-3 * $sqrt(xr * xr + yr * yr) + 1.0 / 16384.0);
  endtask

  task automatic fill_zeros();
    q_zero.delete();
    q_ex.delete();
    q_ey.delete();
    q_tol.delete();
    repeat (LAT) begin
      q_zero.push_back(1'b1);
      q_ex.push_back(0.0);
      q_ey.push_back(0.0);
      q_tol.push_back(0.0);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_x2"}, real'(x2), 0.0, 0.0);
    check_val({tag, "_y2"}, real'(y2), 0.0, 0.0);
  endtask

  // Called at a falling edge: drive operands, let one rising edge sample
  // them, then compare the output against the entry from LAT edges ago.
  task automatic run_cycle(input logic [31:0] xb, input logic [31:0] yb, input logic [31:0] ab);
    bit  z;
    real ex, ey, tol;
    x1    = xb;
    y1    = yb;
    angle = ab;
    @(posedge clk);
    push_model(xb, yb, ab);
    @(negedge clk);
    z   = q_zero.pop_front();
    ex  = q_ex.pop_front();
    ey  = q_ey.pop_front();
    tol = q_tol.pop_front();
    if (z) begin
      check_zero("empty");
    end else begin
      check_val("x2", f2r(x2), ex, tol);
      check_val("y2", f2r(y2), ey, tol);
    end
  endtask

  real dir_x [8] = '{1.0, 0.0, 0.0, 10.0, 4.0,  6.0, 1.0,    1.0};
  real dir_y [8] = '{0.0, 1.0, 1.0, 10.0, 4.0, 16.0, 0.0,    0.0};
  real dir_a [8] = '{45.0, 90.0, 0.0, 10.0, 30.0, 60.0, 150.0, -120.0};

  initial begin
    clr   = 1'b0;
    x1    = 32'h0;
    y1    = 32'h0;
    angle = 32'h0;
    fill_zeros();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    clr = 1'b1;

    repeat (LAT) run_cycle(32'h0, 32'h0, 32'h0);

    for (int k = 0; k < 8; k++)
      run_cycle(r2f(dir_x[k]), r2f(dir_y[k]), r2f(dir_a[k]));

    repeat (40) run_cycle(r2f(rand_coord()), r2f(rand_coord()), r2f(rand_angle()));

    // Reset with operands in flight: everything in the pipe is discarded
    repeat (5) run_cycle(r2f(rand_coord()), r2f(rand_coord()), r2f(rand_angle()));
    clr = 1'b0;
    #1;
    check_zero("midrst");
    fill_zeros();
    x1    = r2f(7.0);
    y1    = r2f(-3.0);
    angle = r2f(20.0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("midrst_hold");
    clr = 1'b1;

    repeat (20) run_cycle(r2f(rand_coord()), r2f(rand_coord()), r2f(rand_angle()));
    repeat (LAT) run_cycle(32'h0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
